// File: rtl/wb_trace_fifo_if.sv
// Bus bundle between the W-stage capture port, the trace consumer and wb_trace_fifo.
// Optional member drop_cnt exists only when WB_TRACE_DROPCNT_EN is defined.
interface wb_trace_fifo_if #(
  parameter int unsigned AW = 4
);
  // W-stage capture group
  logic          w_grf_we;
  logic [4:0]    w_grf_addr;
  logic [31:0]   w_grf_wdata;
  logic [31:0]   w_inst_addr;

  // Consumer-side drain handshake and head record
  logic          trace_valid;
  logic          trace_ready;
  logic [31:0]   trace_pc;
  logic [4:0]    trace_reg;
  logic [31:0]   trace_data;

  // Status and loss reporting
  logic [AW:0]   count;
  logic          overflow;
  logic          ovf_clr;
`ifdef WB_TRACE_DROPCNT_EN
  logic [15:0]   drop_cnt;
`endif

  // Producer/consumer side (CPU W stage plus trace consumer)
  modport master (
    output w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr,
    output trace_ready, ovf_clr,
    input  trace_valid, trace_pc, trace_reg, trace_data,
    input  count, overflow
`ifdef WB_TRACE_DROPCNT_EN
    , input drop_cnt
`endif
  );

  // FIFO side
  modport slave (
    input  w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr,
    input  trace_ready, ovf_clr,
    output trace_valid, trace_pc, trace_reg, trace_data,
    output count, overflow
`ifdef WB_TRACE_DROPCNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: first-word-fall-through trace buffer for committed GRF writes.
// Never back-pressures the CPU; records arriving while full are dropped and
// flagged in the sticky overflow bit.
// Optional feature macro: WB_TRACE_DROPCNT_EN adds a saturating 16-bit
// dropped-record counter (drop_cnt).
module wb_trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  wb_trace_fifo_if.slave  bus
);

  localparam int unsigned CW       = AW + 1;
  localparam int unsigned DCW      = 16;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // One stored trace record: {PC, destination register, data}
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } trace_rec_t;

  trace_rec_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            ovf_q;

  logic            push_c;
  logic            pop_c;
  logic            full_c;
  logic            empty_c;
  logic            wr_en_c;
  logic            drop_c;
  logic [CW-1:0]   cnt_nxt_c;
  trace_rec_t      wr_rec_c;
  trace_rec_t      head_c;

  // Capture/drain decode; a pop while full frees the slot for a same-cycle push
  always_comb begin
    push_c    = 1'b0;
    pop_c     = 1'b0;
    full_c    = 1'b0;
    empty_c   = 1'b0;
    wr_en_c   = 1'b0;
    drop_c    = 1'b0;
    cnt_nxt_c = cnt;
    wr_rec_c  = '0;

    full_c   = (cnt == FULL_CNT);
    empty_c  = (cnt == '0);
    push_c   = bus.w_grf_we && (bus.w_grf_addr != 5'd0);
    pop_c    = !empty_c && bus.trace_ready;
    wr_en_c  = push_c && (!full_c || pop_c);
    drop_c   = push_c && full_c && !pop_c;

    wr_rec_c.pc   = bus.w_inst_addr;
    wr_rec_c.rd   = bus.w_grf_addr;
    wr_rec_c.data = bus.w_grf_wdata;

    case ({wr_en_c, pop_c})
      2'b10:   cnt_nxt_c = cnt + CW'(1);
      2'b01:   cnt_nxt_c = cnt - CW'(1);
      default: cnt_nxt_c = cnt;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)   rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt_nxt_c;
    end
  end

  // Record storage; contents survive reset, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= wr_rec_c;
  end

  // Sticky overflow; a drop wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (drop_c) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef WB_TRACE_DROPCNT_EN
  logic [DCW-1:0] drop_cnt_q;

  // Saturating dropped-record counter; clear plus drop restarts at one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (bus.ovf_clr) begin
      drop_cnt_q <= drop_c ? DCW'(1) : '0;
    end else if (drop_c && (drop_cnt_q != {DCW{1'b1}})) begin
      drop_cnt_q <= drop_cnt_q + DCW'(1);
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

  // FWFT head: fields come straight from the slot under the read pointer
  assign head_c          = mem[rd_ptr];
  assign bus.trace_valid = (cnt != '0);
  assign bus.trace_pc    = head_c.pc;
  assign bus.trace_reg   = head_c.rd;
  assign bus.trace_data  = head_c.data;
  assign bus.count       = cnt;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_wb_trace_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  logic clk;
  logic reset;

  wb_trace_fifo_if #(.AW(AW)) bus ();

  wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  rec_t q[$];
  logic m_ovf = 1'b0;
  int   m_dc  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic we, input logic [4:0] addr,
                        input logic [31:0] data, input logic [31:0] pc);
    bus.w_grf_we    = we;
    bus.w_grf_addr  = addr;
    bus.w_grf_wdata = data;
    bus.w_inst_addr = pc;
  endtask

  // Compare every visible output with the model
  task automatic check_state(input string tag);
    chk({tag, "_count"}, 64'(bus.count), 64'(q.size()));
    chk({tag, "_valid"}, 64'(bus.trace_valid), 64'(q.size() != 0));
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'(m_ovf));
`ifdef WB_TRACE_DROPCNT_EN
    chk({tag, "_dropcnt"}, 64'(bus.drop_cnt), 64'(m_dc));
`endif
    if (q.size() != 0) begin
      chk({tag, "_pc"}, 64'(bus.trace_pc), 64'(q[0].pc));
      chk({tag, "_reg"}, 64'(bus.trace_reg), 64'(q[0].rd));
      chk({tag, "_data"}, 64'(bus.trace_data), 64'(q[0].data));
    end
  endtask

  // Apply current inputs for one edge, advancing the model alongside
  task automatic cycle(input string tag);
    int   sz0;
    logic push, pop, dropped;
    rec_t r;
    sz0     = q.size();
    push    = bus.w_grf_we && (bus.w_grf_addr != 5'd0);
    pop     = (sz0 != 0) && bus.trace_ready;
    dropped = push && (sz0 == DEPTH) && !pop;
    r.pc    = bus.w_inst_addr;
    r.rd    = bus.w_grf_addr;
    r.data  = bus.w_grf_wdata;
    if (pop) void'(q.pop_front());
    if (push && !dropped) q.push_back(r);
    if (dropped) m_ovf = 1'b1;
    else if (bus.ovf_clr) m_ovf = 1'b0;
    if (bus.ovf_clr) m_dc = dropped ? 1 : 0;
    else if (dropped && m_dc != 16'hFFFF) m_dc++;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 32'h0);
    bus.trace_ready = 1'b0;
    bus.ovf_clr     = 1'b0;
    #2;
    chk("rst_valid", 64'(bus.trace_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
`ifdef WB_TRACE_DROPCNT_EN
    chk("rst_dropcnt", 64'(bus.drop_cnt), 64'd0);
`endif
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // Single write then single pop
    set_in(1'b1, 5'd5, 32'h1234, 32'h3000);
    cycle("single");
    chk("single_valid", 64'(bus.trace_valid), 64'd1);
    chk("single_reg", 64'(bus.trace_reg), 64'd5);
    chk("single_data", 64'(bus.trace_data), 64'h1234);
    chk("single_pc", 64'(bus.trace_pc), 64'h3000);
    chk("single_count", 64'(bus.count), 64'd1);
    set_in(1'b0, 5'd0, 32'h0, 32'h0);
    bus.trace_ready = 1'b1;
    cycle("single_pop");
    chk("single_pop_count", 64'(bus.count), 64'd0);
    chk("single_pop_valid", 64'(bus.trace_valid), 64'd0);

    // Writes to $0 are filtered
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h4000 + 32'(4 * i));
      cycle("r0");
      chk("r0_count", 64'(bus.count), 64'd0);
      chk("r0_valid", 64'(bus.trace_valid), 64'd0);
    end

    // Fill past capacity: two drops
    for (int i = 1; i <= 18; i++) begin
      set_in(1'b1, 5'(1 + (i % 31)), 32'(i), 32'h1000 + 32'(4 * i));
      cycle("fill");
    end
    chk("fill_count", 64'(bus.count), 64'd16);
    chk("fill_ovf", 64'(bus.overflow), 64'd1);
`ifdef WB_TRACE_DROPCNT_EN
    chk("fill_dropcnt", 64'(bus.drop_cnt), 64'd2);
`endif
    set_in(1'b0, 5'd0, 32'h0, 32'h0);
    bus.trace_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk("drain_order", 64'(bus.trace_data), 64'(k));
      cycle("drain");
    end
    chk("drain_empty", 64'(bus.count), 64'd0);

    // Clear overflow, refill exactly, then push+pop while full
    bus.trace_ready = 1'b0;
    bus.ovf_clr     = 1'b1;
    cycle("clr");
    chk("clr_ovf", 64'(bus.overflow), 64'd0);
    bus.ovf_clr = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      set_in(1'b1, 5'd9, 32'(100 + i), 32'h2000 + 32'(4 * i));
      cycle("refill");
    end
    set_in(1'b1, 5'd9, 32'd200, 32'h2100);
    bus.trace_ready = 1'b1;
    cycle("fullpp");
    chk("fullpp_count", 64'(bus.count), 64'd16);
    chk("fullpp_ovf", 64'(bus.overflow), 64'd0);
    chk("fullpp_head", 64'(bus.trace_data), 64'd102);
    set_in(1'b0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) cycle("fullpp_drain");
    chk("fullpp_empty", 64'(bus.count), 64'd0);

    // Sustained streaming with ready held high
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_in(1'b1, 5'd7, 32'(i), 32'h5000 + 32'(4 * i));
      cycle("stream");
      chk("stream_cnt_le1", 64'(bus.count <= 5'd1), 64'd1);
      chk("stream_data", 64'(bus.trace_data), 64'(i));
    end
    chk("stream_noovf", 64'(bus.overflow), 64'd0);
    set_in(1'b0, 5'd0, 32'h0, 32'h0);
    cycle("stream_tail");

    // Asynchronous reset mid-operation
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 5'd3, 32'hA000 + 32'(i), 32'h6000 + 32'(4 * i));
      cycle("pre_rst");
    end
    chk("pre_rst_count", 64'(bus.count), 64'd7);
    set_in(1'b0, 5'd0, 32'h0, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.trace_valid), 64'd0);
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_ovf", 64'(bus.overflow), 64'd0);
`ifdef WB_TRACE_DROPCNT_EN
    chk("arst_dropcnt", 64'(bus.drop_cnt), 64'd0);
`endif
    q.delete();
    m_ovf = 1'b0;
    m_dc  = 0;
    #1 reset = 1'b1;
    set_in(1'b1, 5'd11, 32'hBEEF, 32'h7000);
    cycle("post_rst");
    chk("post_rst_count", 64'(bus.count), 64'd1);
    chk("post_rst_data", 64'(bus.trace_data), 64'hBEEF);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int unsigned mode;
      mode = (i / 500) % 3;
      set_in(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             $urandom, $urandom);
      case (mode)
        0:       bus.trace_ready = ($urandom_range(0, 3) == 0);
        1:       bus.trace_ready = ($urandom_range(0, 3) != 0);
        default: bus.trace_ready = $urandom_range(0, 1) != 0;
      endcase
      bus.ovf_clr = ($urandom_range(0, 40) == 0);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Write-back trace buffer sitting directly downstream of the pipelined CPU's W stage. Captures every committed GRF write from the `w_grf_*` / `w_inst_addr` port group into a first-word-fall-through FIFO. Drains records to a consumer (trace UART, bench scoreboard) over a valid/ready handshake. Back-pressure on the consumer side never stalls the CPU: on overflow, records are dropped and flagged.

## Interface
- `DEPTH`, 16, number of record slots; power of two, 2..256.
- `AW`, 4, pointer width; must equal log2(`DEPTH`).
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low; asserting it (0) clears all state immediately.
- `w_grf_we` input 1: GRF write enable from the W stage.
- `w_grf_addr` input 5: destination register.
- `w_grf_wdata` input 32: value written.
- `w_inst_addr` input 32: PC of the writing instruction.
- `trace_valid` output 1: head record available.
- `trace_ready` input 1: consumer accepts the head record.
- `trace_pc` output 32: head record PC.
- `trace_reg` output 5: head record register.
- `trace_data` output 32: head record data.
- `count` output AW+1: occupied slots, 0..`DEPTH`.
- `overflow` output 1: sticky flag; set when a record was dropped.
- `ovf_clr` input 1: synchronous clear of `overflow`.
- `drop_cnt` output 16: dropped-record count; present only with `WB_TRACE_DROPCNT_EN`.

## Operation
- Capture condition (`push`): `w_grf_we`=1 and `w_grf_addr`≠0. Writes to $0 are never recorded.
- Record format: {PC[31:0], reg[4:0], data[31:0]}, 69 bits, stored in a DEPTH-entry array.
- Pointers:
  - `wr_ptr` and `rd_ptr` are AW bits wide and wrap modulo `DEPTH`.
  - `count` is tracked explicitly.
  - full ⇔ `count`==`DEPTH`; empty ⇔ `count`==0.
- `pop` = `trace_valid` & `trace_ready`.
- `trace_valid` = (`count`≠0). Head fields are driven combinationally from `mem[rd_ptr]` (FWFT). When empty, the head fields are don't-care.
- Per-cycle state update:
  - push only, not full: write at `wr_ptr`; `wr_ptr`+1; `count`+1.
  - push only, full: record dropped; `overflow`←1; pointers and `count` unchanged.
  - pop only: `rd_ptr`+1; `count`−1.
  - push and pop, not empty: write and read both proceed; `count` unchanged. When full, this frees the head slot, so the push is accepted and nothing is dropped.
  - push with empty FIFO: accepted; the new record is never popped in the same cycle because `trace_valid` was 0.
- `overflow`:
  - set has priority over `ovf_clr` in the same cycle.
  - `ovf_clr` with no drop clears it on the next edge.
- Reset (`reset`=0), asynchronous, including mid-drain or mid-burst:
  - cleared: `wr_ptr`, `rd_ptr`, `count`, `overflow`, `drop_cnt`.
  - storage array is not cleared.
  - all records in flight are discarded.
- Handshake rules: the consumer may hold `trace_ready` high continuously. While `trace_valid`=1 and `trace_ready`=0, the head fields are stable; a push does not alter them.

## Timing
- Capture latency: a record pushed at edge N appears at the head with `trace_valid`=1 after edge N, provided the FIFO was empty.
- Sustained throughput: one push and one pop per cycle.
- `count` and `overflow` are registered and update at the edge following the event.
- Reset values: `trace_valid`=0, `count`=0, `overflow`=0, `drop_cnt`=0.
- No combinational path from `trace_ready` to `trace_valid`. `trace_ready` combinationally affects only internal `pop`.

## Configuration
- Macro: `WB_TRACE_DROPCNT_EN`.
- Defined:
  - adds the `drop_cnt` port, a 16-bit counter.
  - increments once per dropped record and saturates at 16'hFFFF.
  - cleared by reset and by `ovf_clr`. A drop in the same cycle as `ovf_clr` leaves the counter at 1.
- Undefined: no `drop_cnt` port and no counter logic; `overflow` is the only loss indication.

## Test plan
- Reset then single write: drive we=1, addr=5, wdata=32'h1234, pc=32'h3000 for one cycle with `trace_ready`=0. Required: next cycle `trace_valid`=1, `trace_reg`=5, `trace_data`=32'h1234, `trace_pc`=32'h3000, `count`=1. Raise ready for one cycle → `count`=0, `trace_valid`=0.
- $0 filter: we=1, addr=0, wdata=32'hFFFF_FFFF for 3 cycles. Required: `count` stays 0 and `trace_valid` stays 0.
- Fill and drop: 18 consecutive pushes with DEPTH=16 and ready=0. Required:
  - `count`=16 and `overflow`=1.
  - `drop_cnt`=2 (with macro).
  - draining 16 pops returns records 1..16 in order, wrapping pointers correctly.
- Full with simultaneous push+pop: FIFO full, ready=1 and push in the same cycle. Required: `count` stays 16, `overflow` stays 0, the new record is accepted, and the head advances to record 2.
- Sustained streaming: ready=1 and 40 back-to-back pushes with data=i. Required: `count` ≤1 throughout, no drops, consumer sees data 0..39 in order with no gaps.
- Async reset mid-operation: `count`=7; pulse `reset` low between edges. Required: `trace_valid`, `count`, `overflow`, `drop_cnt` go to 0 immediately. The first push after release appears at the head with `count`=1.
